// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared types, opcodes and the arithmetic helper for the
//             calculator sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam int         RES_W     = 5;
    localparam int         WR_DATA_W = 6;

    // Evaluate A op B and return {neg, magnitude[4:0]}. Subtraction yields a
    // sign/magnitude result so the display never has to handle two's complement.
    function automatic logic [WR_DATA_W-1:0] calc_eval(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] op
    );
        logic [RES_W-1:0] ea;
        logic [RES_W-1:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        if (op == OP_SUB) begin
            if (a >= b) begin
                return {1'b0, ea - eb};
            end
            return {1'b1, eb - ea};
        end
        return {1'b0, ea + eb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_bin5_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin5_to_bcd
//  Purpose  : Combinational 5-bit binary (0..31) to two BCD digits.
//  Revision : 1.0  initial release
// ============================================================================
module bin5_to_bcd (
    input  logic [4:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    // Range compare is cheaper than a generic double-dabble for 0..31.
    always_comb begin
        tens_o = 4'd0;
        ones_o = 4'd0;
        if (bin_i >= 5'd30) begin
            tens_o = 4'd3;
            ones_o = 4'(bin_i - 5'd30);
        end else if (bin_i >= 5'd20) begin
            tens_o = 4'd2;
            ones_o = 4'(bin_i - 5'd20);
        end else if (bin_i >= 5'd10) begin
            tens_o = 4'd1;
            ones_o = 4'(bin_i - 5'd10);
        end else begin
            tens_o = 4'd0;
            ones_o = bin_i[3:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : calc_sequencer
//  Purpose  : Token-driven control FSM evaluating A op B, writing each result
//             to the result register file and holding it for BCD display.
//  Revision : 1.0  initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter bit SUB_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_is_op,
    input  logic [3:0]           in_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WR_DATA_W-1:0] wr_data,
    output logic                 res_valid,
    output logic                 res_neg,
    output logic [3:0]           res_tens,
    output logic [3:0]           res_ones,
    output logic                 err
);

    state_t              state_q;
    logic [3:0]          a_q;
    logic [3:0]          b_q;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [RES_W-1:0]    mag_q;
    logic                neg_q;
    logic                valid_q;
    logic                err_q;

    logic [WR_DATA_W-1:0] res_d;
    logic [ADDR_W-1:0]    wr_ptr_d;
    logic                 xfer;
    logic                 op_legal;

    assign xfer     = in_valid && in_ready;
    assign op_legal = (in_data == OP_ADD) || (SUB_EN && (in_data == OP_SUB));
    assign res_d    = calc_eval(a_q, b_q, op_q);
    assign wr_ptr_d = wr_ptr_q + 1'b1;

    // EXEC is the only cycle that cannot take a token; the write strobe is
    // gated by clear so a cleared EXEC never reaches the register file.
    assign in_ready = (state_q != EXEC);
    assign wr_en    = (state_q == EXEC) && !clear;
    assign wr_addr  = wr_ptr_q;
    assign wr_data  = res_d;

    assign res_valid = valid_q;
    assign res_neg   = neg_q;
    assign err       = err_q;

    // Sequencer FSM with its operand, result, pointer and error registers.
    always_ff @(posedge clk) begin
        err_q <= 1'b0;
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 4'd0;
            wr_ptr_q <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (clear) begin
            // Pointer survives a soft clear; any token this cycle is dropped.
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 4'd0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (in_is_op) begin
                            err_q <= 1'b1;
                        end else begin
                            a_q     <= in_data;
                            state_q <= GOT_A;
                        end
                    end
                end
                GOT_A: begin
                    if (xfer) begin
                        if (!in_is_op) begin
                            a_q <= in_data;
                        end else if (op_legal) begin
                            op_q    <= in_data;
                            state_q <= GOT_OP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GOT_OP: begin
                    if (xfer) begin
                        if (!in_is_op) begin
                            b_q     <= in_data;
                            state_q <= EXEC;
                        end else if (op_legal) begin
                            op_q <= in_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    mag_q    <= res_d[RES_W-1:0];
                    neg_q    <= res_d[WR_DATA_W-1];
                    valid_q  <= 1'b1;
                    wr_ptr_q <= wr_ptr_d;
                    state_q  <= SHOW;
                end
                SHOW: begin
                    // Previous result stays on display while a new A is entered.
                    if (xfer) begin
                        if (in_is_op) begin
                            err_q <= 1'b1;
                        end else begin
                            a_q     <= in_data;
                            state_q <= GOT_A;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bin5_to_bcd u_bcd (
        .bin_i  (mag_q),
        .tens_o (res_tens),
        .ones_o (res_ones)
    );

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_sequencer
//  Purpose  : Self-checking bench for calc_sequencer (table plus directed
//             corner sequences). A second instance has subtraction disabled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;

    typedef struct {
        logic [3:0] a;
        logic [3:0] op;
        logic [3:0] b;
        logic [5:0] wdata;
        logic       neg;
        logic [3:0] tens;
        logic [3:0] ones;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, clear, in_valid, in_is_op;
    logic [3:0] in_data;

    logic       in_ready, wr_en, res_valid, res_neg, err;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic [3:0] res_tens, res_ones;

    logic       in_ready1, wr_en1, res_valid1, res_neg1, err1;
    logic [1:0] wr_addr1;
    logic [5:0] wr_data1;
    logic [3:0] res_tens1, res_ones1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.ADDR_W(2), .SUB_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_is_op(in_is_op), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .res_valid(res_valid), .res_neg(res_neg), .res_tens(res_tens),
        .res_ones(res_ones), .err(err)
    );

    calc_sequencer #(.ADDR_W(2), .SUB_EN(1'b0)) dut_nosub (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready1), .in_is_op(in_is_op), .in_data(in_data),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .res_valid(res_valid1), .res_neg(res_neg1), .res_tens(res_tens1),
        .res_ones(res_ones1), .err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one token (or idle) for a single clock; returns 1ns after the edge.
    task automatic drive(input logic v, input logic op, input logic [3:0] d);
        @(negedge clk);
        in_valid = v;
        in_is_op = op;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"},  in_ready,  1);
        chk({tag, " wr_en"},     wr_en,     0);
        chk({tag, " wr_addr"},   wr_addr,   0);
        chk({tag, " wr_data"},   wr_data,   0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " res_neg"},   res_neg,   0);
        chk({tag, " res_tens"},  res_tens,  0);
        chk({tag, " res_ones"},  res_ones,  0);
        chk({tag, " err"},       err,       0);
    endtask

    vec_t vecs [5];
    logic [1:0] exp_ptr;

    initial begin
        vecs[0] = '{a:4'd9,  op:4'h0, b:4'd7,  wdata:6'h10, neg:1'b0, tens:4'd1, ones:4'd6};
        vecs[1] = '{a:4'd15, op:4'h0, b:4'd15, wdata:6'h1E, neg:1'b0, tens:4'd3, ones:4'd0};
        vecs[2] = '{a:4'd3,  op:4'h1, b:4'd8,  wdata:6'h25, neg:1'b1, tens:4'd0, ones:4'd5};
        vecs[3] = '{a:4'd12, op:4'h1, b:4'd4,  wdata:6'h08, neg:1'b0, tens:4'd0, ones:4'd8};
        vecs[4] = '{a:4'd5,  op:4'h1, b:4'd5,  wdata:6'h00, neg:1'b0, tens:4'd0, ones:4'd0};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_is_op = 1'b0; in_data = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Error handling from IDLE and GOT_A, then digit replacement: 4 + 1.
        drive(1, 1, 4'h0);
        chk("idle op err", err, 1);
        drive(0, 0, 4'h0);
        chk("err one cycle", err, 0);
        drive(1, 0, 4'd2);
        chk("idle digit no err", err, 0);
        drive(1, 1, 4'h7);
        chk("illegal op err", err, 1);
        drive(1, 0, 4'd4);
        chk("digit replace no err", err, 0);
        drive(1, 1, 4'h0);
        chk("legal op no err", err, 0);
        drive(1, 0, 4'd1);
        chk("err seq wr_en", wr_en, 1);
        chk("err seq in_ready", in_ready, 0);
        chk("err seq wr_addr", wr_addr, 0);
        chk("err seq wr_data", wr_data, 6'h05);
        drive(0, 0, 4'h0);
        chk("err seq res_valid", res_valid, 1);
        chk("err seq res_ones", res_ones, 5);
        chk("err seq res_tens", res_tens, 0);
        chk("err seq wr_en off", wr_en, 0);
        exp_ptr = 2'd1;

        // Table: five operations, write address wraps 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, vecs[i].a);
            chk("show holds valid", res_valid, 1);
            drive(1, 1, vecs[i].op);
            chk("op err", err, 0);
            chk("nosub op err", err1, (vecs[i].op == 4'h1) ? 1 : 0);
            drive(1, 0, vecs[i].b);
            chk("exec in_ready", in_ready, 0);
            chk("exec wr_en", wr_en, 1);
            chk("exec wr_addr", wr_addr, exp_ptr);
            chk("exec wr_data", wr_data, vecs[i].wdata);
            chk("nosub wr_en", wr_en1, (vecs[i].op == 4'h1) ? 0 : 1);
            drive(0, 0, 4'h0);
            chk("res_valid", res_valid, 1);
            chk("res_neg", res_neg, vecs[i].neg);
            chk("res_tens", res_tens, vecs[i].tens);
            chk("res_ones", res_ones, vecs[i].ones);
            chk("post in_ready", in_ready, 1);
            chk("post wr_en", wr_en, 0);
            exp_ptr = exp_ptr + 2'd1;
        end

        // Clear during EXEC: no write, pointer kept, result zeroed, token dropped.
        drive(1, 0, 4'd6);
        drive(1, 1, 4'h0);
        drive(1, 0, 4'd2);
        chk("pre-clear wr_en", wr_en, 1);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_is_op = 1'b1; in_data = 4'h5;
        #1;
        chk("clear gates wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        chk("clear res_valid", res_valid, 0);
        chk("clear res_neg", res_neg, 0);
        chk("clear res_tens", res_tens, 0);
        chk("clear res_ones", res_ones, 0);
        chk("clear drops token err", err, 0);
        chk("clear in_ready", in_ready, 1);
        clear = 1'b0; in_valid = 1'b0;
        drive(1, 1, 4'h0);
        chk("clear -> idle op err", err, 1);
        drive(1, 0, 4'd1);
        drive(1, 1, 4'h0);
        drive(1, 0, 4'd1);
        chk("after clear wr_addr", wr_addr, exp_ptr);
        chk("after clear wr_data", wr_data, 6'h02);
        drive(0, 0, 4'h0);
        chk("after clear res_ones", res_ones, 2);

        // Reset in GOT_OP: everything back to reset values, pointer zeroed.
        drive(1, 0, 4'd3);
        drive(1, 1, 4'h0);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 4'd1);
        drive(1, 1, 4'h0);
        drive(1, 0, 4'd1);
        chk("post rst wr_addr", wr_addr, 0);
        chk("post rst wr_data", wr_data, 6'h02);
        drive(0, 0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
